sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Round-robin arbiter that shares the single SDRAM command path of `wb_sdram_ctrl` between `WB_PORTS` per-port buffers and the refresh timer. It sits in the `sdram_clk` domain, after the per-port clock-domain-crossing buffers and before the SDRAM command FSM. It grants exactly one burst transaction at a time and holds the grant until the controller reports burst completion.

## Interface
Parameters:
- `WB_PORTS`, 3: number of requesting ports. Legal range 1–16.
- `ADDR_WIDTH`, 32: width of the per-port burst start address.

Ports:
- `sdram_clk`, in, 1: clock.
- `sdram_rst`, in, 1: reset. Synchronous, active-high.
- `port_req`, in, `WB_PORTS`: port i has a pending burst. Held high until `port_done[i]`.
- `port_we`, in, `WB_PORTS`: direction of port i's burst (1 = write).
- `port_adr`, in, `WB_PORTS*ADDR_WIDTH`: start address of port i's burst, in slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `port_gnt`, out, `WB_PORTS`: one-hot grant. Registered.
- `port_done`, out, `WB_PORTS`: one-cycle pulse when port i's burst completes.
- `ctrl_req`, out, 1: command request to the SDRAM FSM.
- `ctrl_we`, out, 1: registered copy of the granted port's `port_we`.
- `ctrl_adr`, out, `ADDR_WIDTH`: registered copy of the granted port's `port_adr`.
- `ctrl_ack`, in, 1: the FSM has accepted the command.
- `ctrl_done`, in, 1: the FSM has finished the burst.
- `refresh_req`, in, 1: the refresh timer requests an auto-refresh.
- `refresh_gnt`, out, 1: refresh granted. Registered.
- `refresh_done`, in, 1: refresh sequence has finished.

## Operation
State machine:
- States: IDLE, CMD, BUSY, REFRESH.
- IDLE:
  - `refresh_req` high → REFRESH, `refresh_gnt`=1.
  - Otherwise, if any `port_req` bit is high → CMD. The grant goes to the first requesting port found searching upward (modulo `WB_PORTS`) from `last+1`. `ctrl_we`/`ctrl_adr` are latched from that port, `ctrl_req`=1, and `last` is updated to the granted index.
- CMD: `ctrl_req` stays high until `ctrl_ack`.
  - `ctrl_ack` alone → BUSY, `ctrl_req`=0.
  - `ctrl_ack` and `ctrl_done` in the same cycle → IDLE, `port_done` pulse.
- BUSY: `ctrl_done` → IDLE. `port_gnt` clears and the matching `port_done` bit pulses for one cycle.
- REFRESH: `refresh_done` → IDLE, `refresh_gnt`=0.

Grant and request rules:
- `ctrl_we`/`ctrl_adr` are frozen for the whole grant. Changes on `port_*` during a grant are ignored.
- If a granted port drops `port_req` early, the transaction still completes and `port_done` still pulses.
- `refresh_req` raised during CMD/BUSY waits and wins at the next IDLE.
- `ctrl_ack`/`ctrl_done` outside CMD/BUSY are ignored. `refresh_done` outside REFRESH is ignored.
- At most one of `port_gnt`/`refresh_gnt` is ever high.

Reset values:
- State IDLE.
- `port_gnt`=0, `port_done`=0, `ctrl_req`=0, `ctrl_we`=0, `ctrl_adr`=0, `refresh_gnt`=0.
- `last`=`WB_PORTS-1`, so port 0 has first priority.
- Reset in any state aborts to IDLE within one cycle and emits no `port_done`.

## Timing
- `port_req` sampled high in IDLE → `port_gnt`/`ctrl_req` high on the next edge (1-cycle latency).
- `ctrl_done` high in BUSY → `port_done` pulse and `port_gnt` low on the next edge. The next arbitration happens in IDLE on the following cycle.
- Minimum port-to-port turnaround: 1 IDLE cycle between grants.
- `refresh_req` in IDLE → `refresh_gnt` on the next edge. `refresh_done` → `refresh_gnt` low on the next edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SDRAM_ARB_REFRESH_EN` defined: refresh arbitration is active as described in Operation.
- `SDRAM_ARB_REFRESH_EN` undefined:
  - REFRESH state is removed.
  - `refresh_req` and `refresh_done` are ignored; `refresh_gnt` is tied 0.
  - Refresh is then sequenced externally (the SDRAM FSM interleaves it between bursts).

## Test plan
- Reset: assert `sdram_rst` for 2 cycles with all `port_req`=3'b111 → all outputs 0 during reset. On the first cycle after reset, `port_gnt`=3'b001.
- Single port: port 1 requests, `port_we`=1, `port_adr`=32'h0000_1000. Ack 2 cycles later, done 8 cycles later → `ctrl_adr`=32'h1000, `ctrl_we`=1, `ctrl_req` high for exactly 3 cycles, one `port_done`=3'b010 pulse.
- Fairness: all three ports request continuously → grant order 0,1,2,0,1,2, with exactly 1 IDLE cycle between grants.
- Refresh priority (macro defined): `refresh_req` and `port_req`=3'b001 rise together in IDLE → `refresh_gnt` first. After `refresh_done`, `port_gnt`=3'b001. With the macro undefined, the same stimulus → `refresh_gnt` stays 0 and port 0 is granted immediately.
- Boundaries:
  - `ctrl_ack` and `ctrl_done` together in CMD → direct return to IDLE with a single `port_done` pulse.
  - Granted port drops `port_req` in BUSY → `port_done` still pulses.
- Reset mid-BUSY on port 2 → no `port_done`. Next grant is port 0.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Port-buffer / refresh-timer / SDRAM-FSM signal bundle seen by sdram_port_arbiter.
// slave = arbiter side, master = requesters plus command FSM (or a bench).
interface sdram_port_arbiter_if #(
  parameter int WB_PORTS   = 3,
  parameter int ADDR_WIDTH = 32
);
  logic [WB_PORTS-1:0]            port_req;
  logic [WB_PORTS-1:0]            port_we;
  logic [WB_PORTS*ADDR_WIDTH-1:0] port_adr;
  logic [WB_PORTS-1:0]            port_gnt;
  logic [WB_PORTS-1:0]            port_done;
  logic                           ctrl_req;
  logic                           ctrl_we;
  logic [ADDR_WIDTH-1:0]          ctrl_adr;
  logic                           ctrl_ack;
  logic                           ctrl_done;
  logic                           refresh_req;
  logic                           refresh_gnt;
  logic                           refresh_done;

  modport slave (
    input  port_req, port_we, port_adr, ctrl_ack, ctrl_done, refresh_req, refresh_done,
    output port_gnt, port_done, ctrl_req, ctrl_we, ctrl_adr, refresh_gnt
  );

  modport master (
    output port_req, port_we, port_adr, ctrl_ack, ctrl_done, refresh_req, refresh_done,
    input  port_gnt, port_done, ctrl_req, ctrl_we, ctrl_adr, refresh_gnt
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter granting one SDRAM burst at a time among WB_PORTS buffers (and refresh).
// Refresh arbitration is compiled in only when SDRAM_ARB_REFRESH_EN is defined.
module sdram_port_arbiter #(
  parameter int WB_PORTS   = 3,
  parameter int ADDR_WIDTH = 32
) (
  input logic                 sdram_clk,
  input logic                 sdram_rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int IDX_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(WB_PORTS - 1);

`ifdef SDRAM_ARB_REFRESH_EN
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_BUSY, S_REFRESH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_BUSY} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_last, w_last_nxt;
  logic [WB_PORTS-1:0]   r_port_gnt, w_port_gnt_nxt;
  logic [WB_PORTS-1:0]   r_port_done, w_port_done_nxt;
  logic                  r_ctrl_req, w_ctrl_req_nxt;
  logic                  r_ctrl_we, w_ctrl_we_nxt;
  logic [ADDR_WIDTH-1:0] r_ctrl_adr, w_ctrl_adr_nxt;
  logic                  w_any;
  logic [IDX_W-1:0]      w_pick;
  int                    w_idx;
  logic                  w_refresh_req;

`ifdef SDRAM_ARB_REFRESH_EN
  logic r_refresh_gnt, w_refresh_gnt_nxt;
  assign w_refresh_req   = bus.refresh_req;
  assign bus.refresh_gnt = r_refresh_gnt;
`else
  logic w_unused_refresh;
  assign w_unused_refresh = bus.refresh_req ^ bus.refresh_done;
  assign w_refresh_req    = 1'b0;
  assign bus.refresh_gnt  = 1'b0;
`endif

  // Scan from last+1 upward; the descending loop lets the nearest requester overwrite the rest.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int k = WB_PORTS; k >= 1; k--) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= WB_PORTS) w_idx = w_idx - WB_PORTS;
      if (bus.port_req[w_idx[IDX_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      r_state       <= S_IDLE;
      r_last        <= LAST_RST;
      r_port_gnt    <= '0;
      r_port_done   <= '0;
      r_ctrl_req    <= 1'b0;
      r_ctrl_we     <= 1'b0;
      r_ctrl_adr    <= '0;
`ifdef SDRAM_ARB_REFRESH_EN
      r_refresh_gnt <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_port_gnt    <= w_port_gnt_nxt;
      r_port_done   <= w_port_done_nxt;
      r_ctrl_req    <= w_ctrl_req_nxt;
      r_ctrl_we     <= w_ctrl_we_nxt;
      r_ctrl_adr    <= w_ctrl_adr_nxt;
`ifdef SDRAM_ARB_REFRESH_EN
      r_refresh_gnt <= w_refresh_gnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef SDRAM_ARB_REFRESH_EN
        if (w_refresh_req)  w_state_nxt = S_REFRESH;
        else if (w_any)     w_state_nxt = S_CMD;
`else
        if (w_any)          w_state_nxt = S_CMD;
`endif
      end
      S_CMD: begin
        if (bus.ctrl_ack) w_state_nxt = bus.ctrl_done ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        if (bus.ctrl_done) w_state_nxt = S_IDLE;
      end
`ifdef SDRAM_ARB_REFRESH_EN
      S_REFRESH: begin
        if (bus.refresh_done) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; command fields stay frozen for the whole grant.
  always_comb begin
    w_last_nxt        = r_last;
    w_port_gnt_nxt    = r_port_gnt;
    w_port_done_nxt   = '0;
    w_ctrl_req_nxt    = r_ctrl_req;
    w_ctrl_we_nxt     = r_ctrl_we;
    w_ctrl_adr_nxt    = r_ctrl_adr;
`ifdef SDRAM_ARB_REFRESH_EN
    w_refresh_gnt_nxt = r_refresh_gnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_refresh_req) begin
`ifdef SDRAM_ARB_REFRESH_EN
          w_refresh_gnt_nxt = 1'b1;
`endif
        end else if (w_any) begin
          w_port_gnt_nxt = WB_PORTS'(1) << w_pick;
          w_ctrl_req_nxt = 1'b1;
          w_ctrl_we_nxt  = bus.port_we[w_pick];
          w_ctrl_adr_nxt = bus.port_adr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          w_last_nxt     = w_pick;
        end
      end
      S_CMD: begin
        if (bus.ctrl_ack) begin
          w_ctrl_req_nxt = 1'b0;
          if (bus.ctrl_done) begin
            w_port_gnt_nxt  = '0;
            w_port_done_nxt = r_port_gnt;
          end
        end
      end
      S_BUSY: begin
        if (bus.ctrl_done) begin
          w_port_gnt_nxt  = '0;
          w_port_done_nxt = r_port_gnt;
        end
      end
`ifdef SDRAM_ARB_REFRESH_EN
      S_REFRESH: begin
        if (bus.refresh_done) w_refresh_gnt_nxt = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign bus.port_gnt  = r_port_gnt;
  assign bus.port_done = r_port_done;
  assign bus.ctrl_req  = r_ctrl_req;
  assign bus.ctrl_we   = r_ctrl_we;
  assign bus.ctrl_adr  = r_ctrl_adr;
endmodule
